// File: rtl/jk_seq_pkg.sv
// Shared types and the per-bit JK excitation rule for the sequencer.
// Exports: state_t (FSM states), DC_* encodings, excite().
package jk_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_CHECK,
        ST_DONE
    } state_t;

    // Don't-care resolution: X->0 gives set/reset style, X->1 toggle style.
    localparam int DC_ZERO = 0;
    localparam int DC_ONE  = 1;

    // Returns {J,K} that moves one flip-flop from q to tgt.
    function automatic logic [1:0] excite(
        input logic q,
        input logic tgt,
        input int   dc_mode
    );
        logic       one;
        logic [1:0] jk;
        one = (dc_mode == DC_ONE);
        case ({q, tgt})
            2'b00: jk = one ? 2'b01 : 2'b00;
            2'b01: jk = one ? 2'b11 : 2'b10;
            2'b10: jk = one ? 2'b11 : 2'b01;
            2'b11: jk = one ? 2'b10 : 2'b00;
        endcase
        return jk;
    endfunction

endpackage

// File: rtl/jk_excite.sv
// WIDTH-wide combinational JK excitation from current to target state.
// Ports: q (current state), tgt (target), j/k (excitation).
module jk_excite
    import jk_seq_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int DC_MODE = 0
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] tgt,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k
);

    always_comb begin
        j = '0;
        k = '0;
        for (int b = 0; b < WIDTH; b++) begin
            {j[b], k[b]} = excite(q[b], tgt[b], DC_MODE);
        end
    end

endmodule

// File: rtl/jk_seq_driver.sv
// Steps an external JK flip-flop bank through stored target states.
// Ports: target write (wr_*), start/len/abort control, q_fb feedback,
// j/k drive, status busy/step_idx/done/err/err_idx.
module jk_seq_driver
    import jk_seq_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int DEPTH   = 8,
    parameter int DC_MODE = 0,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             start,
    input  logic [AW:0]      len,
    input  logic             abort,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic [AW-1:0]    step_idx,
    output logic             done,
    output logic             err,
    output logic [AW-1:0]    err_idx
);

    state_t           state;
    logic [AW-1:0]    idx;
    logic [AW-1:0]    last_idx;
    logic [WIDTH-1:0] tgt_mem [DEPTH];
    logic [WIDTH-1:0] cur_tgt;
    logic [WIDTH-1:0] ex_j;
    logic [WIDTH-1:0] ex_k;
    logic [AW:0]      len_sat;
    logic             miss;

    assign cur_tgt  = tgt_mem[idx];
    assign miss     = (q_fb != cur_tgt);
    assign step_idx = idx;

    always_comb begin
        len_sat = len;
        if (len > (AW+1)'(DEPTH)) begin
            len_sat = (AW+1)'(DEPTH);
        end
    end

    jk_excite #(
        .WIDTH   (WIDTH),
        .DC_MODE (DC_MODE)
    ) u_excite (
        .q   (q_fb),
        .tgt (cur_tgt),
        .j   (ex_j),
        .k   (ex_k)
    );

    // The bank only moves during DRIVE; every other state holds it.
    assign j = (state == ST_DRIVE) ? ex_j : '0;
    assign k = (state == ST_DRIVE) ? ex_k : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            idx      <= '0;
            last_idx <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_idx  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tgt_mem[i] <= '0;
            end
        end else begin
            done <= 1'b0;

            if (wr_en && !busy) begin
                tgt_mem[wr_addr] <= wr_data;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        err <= 1'b0;
                        if (len_sat == '0) begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            idx      <= '0;
                            last_idx <= AW'(len_sat - 1'b1);
                            busy     <= 1'b1;
                            state    <= ST_DRIVE;
                        end
                    end
                end

                ST_DRIVE: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        state <= ST_CHECK;
                    end
                end

                ST_CHECK: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        // Only the first mismatch of a run is recorded.
                        if (miss && !err) begin
                            err     <= 1'b1;
                            err_idx <= idx;
                        end
                        if (idx == last_idx) begin
                            busy  <= 1'b0;
                            done  <= !(err || miss);
                            state <= ST_DONE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= ST_DRIVE;
                        end
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/jk_seq_driver.md
Name: jk_seq_driver

Overview:
- Programmable sequencer that drives the J/K inputs of an external bank of WIDTH JK flip-flops.
- The bank is clocked on the same clk and provides feedback on q_fb.
- Holds up to DEPTH target states. On start it steps the bank through targets 0..len-1, computing J/K excitation from the current q_fb and the next target.
- After each step it checks that the bank reached the target, and flags the first mismatch.

Parameters:
- WIDTH, 4, number of JK flip-flops driven.
- DEPTH, 8, number of target-state entries; power of two.
- DC_MODE, 0, don't-care resolution for excitation: 0 resolves X as 0 (set/reset style), 1 resolves X as 1 (toggle style).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- wr_en  input  1  write target entry; honoured only when busy=0.
- wr_addr  input  log2(DEPTH)  target entry index.
- wr_data  input  WIDTH  target state.
- start  input  1  begin sequence; honoured only when busy=0.
- len  input  log2(DEPTH)+1  number of steps; sampled with start; values above DEPTH saturate to DEPTH.
- abort  input  1  stop the running sequence.
- q_fb  input  WIDTH  q outputs of the external JK bank.
- j  output  WIDTH  J drive.
- k  output  WIDTH  K drive.
- busy  output  1  sequence in progress.
- step_idx  output  log2(DEPTH)  current entry index.
- done  output  1  one-cycle pulse on successful completion.
- err  output  1  sticky mismatch flag; cleared by the next accepted start or by reset.
- err_idx  output  log2(DEPTH)  entry index of the first mismatch.

Behaviour:
- Reset is synchronous and active-high. All outputs go to 0, the FSM goes to IDLE, and every target entry is cleared to 0. Reset mid-run aborts the run at that edge.
- FSM states: IDLE, DRIVE, CHECK, DONE.
- IDLE:
  - j=k=0.
  - start=1 latches len and clears err. With len=0 it goes to DONE; otherwise idx=0, busy=1, next state DRIVE.
- DRIVE (one cycle):
  - j/k = excite(q_fb, target[idx]) combinationally, per bit.
  - DC_MODE=0: 0->0 J0K0; 0->1 J1K0; 1->0 J0K1; 1->1 J0K0.
  - DC_MODE=1: 0->0 J0K1; 0->1 J1K1; 1->0 J1K1; 1->1 J1K0.
  - Next state CHECK.
- CHECK (one cycle):
  - j=k=0, so the bank holds.
  - Compares q_fb with target[idx]. On mismatch with err=0: set err and load err_idx=idx.
  - If idx=len-1, next state is DONE; otherwise idx+1 and back to DRIVE.
  - A mismatch does not stop the sequence.
- DONE (one cycle):
  - done=1 only if err=0; busy=0 in this cycle. Next state IDLE.
- Timing: each step takes 2 cycles, so a full sequence takes 2*len+1 cycles from the start edge to the done pulse.
- abort in DRIVE or CHECK:
  - Next state is IDLE, j=k=0 from the next cycle, busy=0, no done pulse.
  - err and err_idx are retained.
- Simultaneous events:
  - start together with abort in IDLE: start wins.
  - wr_en while busy=1 is ignored; no entry changes.
  - start while busy=1 is ignored.
- step_idx mirrors idx while busy, and holds its last value afterwards.

Decomposition:
- Package jk_seq_pkg:
  - FSM state enum.
  - DC_MODE encodings.
  - Per-bit excitation function excite(q, tgt, dc_mode) returning {J,K}.
- Sub-module jk_excite: combinational WIDTH-wide excitation, instantiated once.
- Target storage: a register array inside jk_seq_driver.
- The bench models the JK bank as WIDTH JK flip-flops with 00 hold, 01 clear, 10 set, 11 toggle, initial q=0.

Test Plan:
- DC_MODE=0: write targets 0x3, 0xC, 0x0, 0xF, start len=4 -> q_fb sequence 3, C, 0, F; done pulses at cycle 9 after start; err=0; in step 1 (3->C), j=0xC and k=0x3.
- DC_MODE=1 with the same targets -> identical q_fb sequence. In step 1, j=0xF and k=0xF. In step 3 (0x0->0xF), j=0xF and k=0xF.
- Bench forces q_fb bit0 stuck at 0 with target[1]=0x1 -> err=1 and err_idx=1 after step-1 CHECK; sequence completes; no done pulse.
- abort asserted in the second DRIVE of a len=4 run -> busy=0 next cycle, j=k=0, no done; a subsequent start with len=4 runs cleanly and clears err.
- start with len=0 -> done pulses 1 cycle after start; j/k stay 0. wr_en to entry 2 during a run is ignored; readback via a len=3 run shows the old value.
- reset asserted mid-CHECK -> the next cycle has all outputs 0 and the FSM in IDLE; a len=1 run afterwards drives target 0x0, so j=k=0 and done follows.
